uart_arbiter: RTL and testbench

Parametrised successor to the fixed three-CPU UART mux: it shares one UART register port among `CPU_NUM` J1 cores. It has two modes. Legacy mode follows a CPU-select number. Round-robin mode uses request/grant arbitration, with per-owner locking and an idle timeout. All UART-side strobes are registered, and each access is acknowledged back to the owning core, so software can poll without guessing the bus latency. It sits between the CPU cluster and the UART core in the top level.

---
 rtl/uart_arbiter_pkg.sv | 19 +
 rtl/uart_arbiter_rr_picker.sv | 33 +++
 rtl/uart_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_uart_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_arbiter_pkg.sv
// Shared types and helpers for the UART port arbiter and later shared
// peripherals built on the same round-robin picker.
package uart_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_e;

  localparam int UART_ADDR_W = 2;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester searching upward from
// ptr_i+1 (mod N). Returns one-hot winner, its index and a valid flag.
module rr_picker
  import uart_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_arbiter.sv
// Shares one UART register port among CPU_NUM cores: legacy fixed select or
// round-robin with lock/idle-timeout; UART strobes registered, accesses acked.
module uart_arbiter
  import uart_arbiter_pkg::*;
#(
  parameter int CPU_NUM = 3,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = UART_ADDR_W,
  parameter int TIMEOUT = 255,
  localparam int IW     = idx_w(CPU_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [IW-1:0]              sel_num,
  input  logic [CPU_NUM-1:0]         cpu_req,
  input  logic [CPU_NUM-1:0]         cpu_lock,
  input  logic [CPU_NUM-1:0]         cpu_rd,
  input  logic [CPU_NUM-1:0]         cpu_wr,
  input  logic [CPU_NUM*ADDR_W-1:0]  cpu_adr,
  input  logic [CPU_NUM*DATA_W-1:0]  cpu_dat_o,
  output logic [CPU_NUM*DATA_W-1:0]  cpu_dat_i,
  output logic [CPU_NUM-1:0]         cpu_ack,
  output logic [CPU_NUM-1:0]         cpu_grant,
  output logic                       timeout_err,
  output logic                       uart_rd,
  output logic                       uart_wr,
  output logic [ADDR_W-1:0]          uart_addr,
  output logic [DATA_W-1:0]          uart_din,
  input  logic [DATA_W-1:0]          uart_dout
);

  localparam int CW = idx_w(TIMEOUT + 1);

  arb_state_e                       state_q, state_d;
  logic [IW-1:0]                    owner_q, owner_d, ptr_q, ptr_d;
  logic [IW-1:0]                    sel_q, sel_own_q, sel_own_d;
  logic                             mode_own_q, mode_own_d;
  logic [CPU_NUM-1:0]               grant_q, grant_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             tout_q, tout_d;
  logic                             urd_q, urd_d, uwr_q, uwr_d, acc_rd_q, acc_rd_d;
  logic [ADDR_W-1:0]                uaddr_q, uaddr_d;
  logic [DATA_W-1:0]                udin_q, udin_d;
  logic [CPU_NUM-1:0][DATA_W-1:0]   dat_q, dat_d, dat_c;

  logic [CPU_NUM-1:0][ADDR_W-1:0]   adr_a;
  logic [CPU_NUM-1:0][DATA_W-1:0]   wdat_a;
  logic [CPU_NUM-1:0]               pick_gnt;
  logic [IW-1:0]                    pick_idx;
  logic                             pick_vld;
  logic                             own_rd, own_wr, sel_ok, tout_hit, rel_legacy;

  assign adr_a  = cpu_adr;
  assign wdat_a = cpu_dat_o;
  assign own_rd = cpu_rd[owner_q];
  assign own_wr = cpu_wr[owner_q];
  assign sel_ok = {1'b0, sel_q} < (IW+1)'(CPU_NUM);

  // Legacy owners re-arbitrate on any select/mode change; RR owners on mode change.
  assign rel_legacy = (mode != mode_own_q) || (!mode_own_q && (sel_q != sel_own_q));
  assign tout_hit   = (TIMEOUT != 0) && mode_own_q && !cpu_lock[owner_q] &&
                      (cnt_q == CW'(TIMEOUT - 1));

  rr_picker #(.N(CPU_NUM), .IW(IW)) u_pick (
    .req_i (cpu_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= IW'(CPU_NUM - 1);
      sel_q      <= '0;
      sel_own_q  <= '0;
      mode_own_q <= 1'b0;
      grant_q    <= '0;
      cnt_q      <= '0;
      tout_q     <= 1'b0;
      urd_q      <= 1'b0;
      uwr_q      <= 1'b0;
      acc_rd_q   <= 1'b0;
      uaddr_q    <= '0;
      udin_q     <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_num;
      sel_own_q  <= sel_own_d;
      mode_own_q <= mode_own_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
      urd_q      <= urd_d;
      uwr_q      <= uwr_d;
      acc_rd_q   <= acc_rd_d;
      uaddr_q    <= uaddr_d;
      udin_q     <= udin_d;
      dat_q      <= dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    sel_own_d  = sel_own_q;
    mode_own_d = mode_own_q;
    grant_d    = grant_q;
    cnt_d      = '0;
    tout_d     = 1'b0;
    urd_d      = 1'b0;
    uwr_d      = 1'b0;
    acc_rd_d   = acc_rd_q;
    uaddr_d    = uaddr_q;
    udin_d     = udin_q;
    dat_d      = dat_q;
    unique case (state_q)
      ST_IDLE: begin
        mode_own_d = mode;
        sel_own_d  = sel_q;
        if (mode) begin
          if (pick_vld) begin
            grant_d = pick_gnt;
            owner_d = pick_idx;
            state_d = ST_OWN;
          end
        end else if (sel_ok) begin
          grant_d = CPU_NUM'(1) << sel_q;
          owner_d = sel_q;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        if (rel_legacy || (mode_own_q && !cpu_req[owner_q]) || (!(own_rd || own_wr) && tout_hit)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          tout_d  = !rel_legacy && cpu_req[owner_q];
          if (mode_own_q) ptr_d = owner_q;
        end else if (own_rd || own_wr) begin
          // Write wins a simultaneous read/write; the read is dropped.
          state_d  = ST_ACCESS;
          uwr_d    = own_wr;
          urd_d    = own_rd && !own_wr;
          acc_rd_d = own_rd && !own_wr;
          uaddr_d  = adr_a[owner_q];
          udin_d   = wdat_a[owner_q];
        end else if (mode_own_q && !cpu_lock[owner_q]) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_OWN;
        if (acc_rd_q) dat_d[owner_q] = uart_dout;
      end
    endcase
  end

  // Read data is valid during DONE, so it is forwarded in that cycle and held after.
  always_comb begin
    cpu_ack = '0;
    dat_c   = dat_q;
    if (state_q == ST_DONE) begin
      cpu_ack = grant_q;
      if (acc_rd_q) dat_c[owner_q] = uart_dout;
    end
  end

  assign cpu_dat_i   = dat_c;
  assign cpu_grant   = grant_q;
  assign timeout_err = tout_q;
  assign uart_rd     = urd_q;
  assign uart_wr     = uwr_q;
  assign uart_addr   = uaddr_q;
  assign uart_din    = udin_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter: a vector table for round-robin, read,
// collision and timeout behaviour, plus hand sequences for lock, legacy and reset.
module tb_uart_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b1;
  logic [1:0]  sel_num = '0;
  logic [2:0]  cpu_req = '0, cpu_lock = '0, cpu_rd = '0, cpu_wr = '0;
  logic [5:0]  cpu_adr = 6'h39;
  logic [23:0] cpu_dat_o = 24'h332211;
  logic [23:0] cpu_dat_i;
  logic [2:0]  cpu_ack, cpu_grant;
  logic        timeout_err, uart_rd, uart_wr;
  logic [1:0]  uart_addr;
  logic [7:0]  uart_din;
  logic [7:0]  uart_dout = '0;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [23:0] DAT  = 24'h332211;
  localparam logic [23:0] DATC = 24'h33C311;

  always #5 clk = ~clk;

  uart_arbiter #(.CPU_NUM(3), .DATA_W(8), .ADDR_W(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst_n), .mode(mode), .sel_num(sel_num),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_adr(cpu_adr), .cpu_dat_o(cpu_dat_o), .cpu_dat_i(cpu_dat_i),
    .cpu_ack(cpu_ack), .cpu_grant(cpu_grant), .timeout_err(timeout_err),
    .uart_rd(uart_rd), .uart_wr(uart_wr), .uart_addr(uart_addr),
    .uart_din(uart_din), .uart_dout(uart_dout)
  );

  typedef struct {
    logic [2:0]  req, lock, rd, wr;
    logic [23:0] dat;
    logic [7:0]  dout;
    logic [2:0]  g, ack;
    logic        urd, uwr;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic        terr;
    logic [23:0] dati;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input logic [2:0] req, lock, rd, wr, input logic [23:0] dat,
                              input logic [7:0] dout, input logic [2:0] g, ack,
                              input logic urd, uwr, input logic [1:0] addr,
                              input logic [7:0] din, input logic terr, input logic [23:0] dati);
    vec_t v;
    v.req = req; v.lock = lock; v.rd = rd; v.wr = wr; v.dat = dat; v.dout = dout;
    v.g = g; v.ack = ack; v.urd = urd; v.uwr = uwr; v.addr = addr; v.din = din;
    v.terr = terr; v.dati = dati;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " grant"}, 32'(cpu_grant), 0);
    chk({nm, " ack"}, 32'(cpu_ack), 0);
    chk({nm, " uart_rd"}, 32'(uart_rd), 0);
    chk({nm, " uart_wr"}, 32'(uart_wr), 0);
    chk({nm, " uart_addr"}, 32'(uart_addr), 0);
    chk({nm, " uart_din"}, 32'(uart_din), 0);
    chk({nm, " dat_i"}, 32'(cpu_dat_i), 0);
    chk({nm, " timeout_err"}, 32'(timeout_err), 0);
  endtask

  initial begin
    //       req lock rd wr dat  dout   g ack urd uwr addr din   terr dati
    tbl[0]  = mk(7, 0, 0, 0, DAT,  8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 24'h0);
    tbl[1]  = mk(7, 0, 0, 1, DAT,  8'h00, 1, 0, 0, 1, 1, 8'h11, 0, 24'h0);
    tbl[2]  = mk(7, 0, 0, 0, DAT,  8'h00, 1, 1, 0, 0, 1, 8'h11, 0, 24'h0);
    tbl[3]  = mk(6, 0, 0, 0, DAT,  8'h00, 1, 0, 0, 0, 1, 8'h11, 0, 24'h0);
    tbl[4]  = mk(6, 0, 0, 0, DAT,  8'h00, 0, 0, 0, 0, 1, 8'h11, 0, 24'h0);
    tbl[5]  = mk(6, 0, 0, 0, DAT,  8'h00, 2, 0, 0, 0, 1, 8'h11, 0, 24'h0);
    tbl[6]  = mk(6, 0, 0, 2, DAT,  8'h00, 2, 0, 0, 1, 2, 8'h22, 0, 24'h0);
    tbl[7]  = mk(6, 0, 0, 0, DAT,  8'h00, 2, 2, 0, 0, 2, 8'h22, 0, 24'h0);
    tbl[8]  = mk(5, 0, 0, 0, DAT,  8'h00, 2, 0, 0, 0, 2, 8'h22, 0, 24'h0);
    tbl[9]  = mk(5, 0, 0, 0, DAT,  8'h00, 0, 0, 0, 0, 2, 8'h22, 0, 24'h0);
    tbl[10] = mk(5, 0, 0, 0, DAT,  8'h00, 4, 0, 0, 0, 2, 8'h22, 0, 24'h0);
    tbl[11] = mk(5, 0, 0, 4, DAT,  8'h00, 4, 0, 0, 1, 3, 8'h33, 0, 24'h0);
    tbl[12] = mk(5, 0, 0, 0, DAT,  8'h00, 4, 4, 0, 0, 3, 8'h33, 0, 24'h0);
    tbl[13] = mk(3, 0, 0, 0, DAT,  8'h00, 4, 0, 0, 0, 3, 8'h33, 0, 24'h0);
    tbl[14] = mk(3, 0, 0, 0, DAT,  8'h00, 0, 0, 0, 0, 3, 8'h33, 0, 24'h0);
    tbl[15] = mk(3, 0, 0, 0, DAT,  8'h00, 1, 0, 0, 0, 3, 8'h33, 0, 24'h0);
    tbl[16] = mk(2, 0, 0, 0, DAT,  8'h00, 0, 0, 0, 0, 3, 8'h33, 0, 24'h0);
    tbl[17] = mk(2, 0, 0, 0, DAT,  8'h00, 2, 0, 0, 0, 3, 8'h33, 0, 24'h0);
    tbl[18] = mk(2, 0, 2, 0, DAT,  8'h5A, 2, 0, 1, 0, 2, 8'h22, 0, 24'h0);
    tbl[19] = mk(2, 0, 0, 0, DAT,  8'h5A, 2, 2, 0, 0, 2, 8'h22, 0, 24'h005A00);
    tbl[20] = mk(2, 0, 0, 0, DAT,  8'h5A, 2, 0, 0, 0, 2, 8'h22, 0, 24'h005A00);
    tbl[21] = mk(2, 0, 0, 0, DAT,  8'h77, 2, 0, 0, 0, 2, 8'h22, 0, 24'h005A00);
    tbl[22] = mk(2, 0, 2, 2, DATC, 8'h77, 2, 0, 0, 1, 2, 8'hC3, 0, 24'h005A00);
    tbl[23] = mk(2, 0, 1, 2, DATC, 8'h77, 2, 2, 0, 0, 2, 8'hC3, 0, 24'h005A00);
    tbl[24] = mk(2, 0, 2, 0, DATC, 8'h77, 2, 0, 0, 0, 2, 8'hC3, 0, 24'h005A00);
    tbl[25] = mk(6, 0, 1, 4, DATC, 8'h77, 2, 0, 0, 0, 2, 8'hC3, 0, 24'h005A00);
    tbl[26] = mk(6, 0, 0, 0, DATC, 8'h77, 2, 0, 0, 0, 2, 8'hC3, 0, 24'h005A00);
    tbl[27] = mk(6, 0, 0, 0, DATC, 8'h77, 2, 0, 0, 0, 2, 8'hC3, 0, 24'h005A00);
    tbl[28] = mk(6, 0, 0, 0, DATC, 8'h77, 0, 0, 0, 0, 2, 8'hC3, 1, 24'h005A00);
    tbl[29] = mk(6, 0, 0, 0, DATC, 8'h77, 4, 0, 0, 0, 2, 8'hC3, 0, 24'h005A00);

    // Reset state
    step(); step();
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin, read path, collision and timeout vectors
    for (int i = 0; i < 30; i++) begin
      cpu_req = tbl[i].req; cpu_lock = tbl[i].lock; cpu_rd = tbl[i].rd; cpu_wr = tbl[i].wr;
      cpu_dat_o = tbl[i].dat; uart_dout = tbl[i].dout;
      step();
      chk($sformatf("row%0d grant", i), 32'(cpu_grant), 32'(tbl[i].g));
      chk($sformatf("row%0d ack", i), 32'(cpu_ack), 32'(tbl[i].ack));
      chk($sformatf("row%0d uart_rd", i), 32'(uart_rd), 32'(tbl[i].urd));
      chk($sformatf("row%0d uart_wr", i), 32'(uart_wr), 32'(tbl[i].uwr));
      chk($sformatf("row%0d uart_addr", i), 32'(uart_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d uart_din", i), 32'(uart_din), 32'(tbl[i].din));
      chk($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'(tbl[i].terr));
      chk($sformatf("row%0d dat_i", i), 32'(cpu_dat_i), 32'(tbl[i].dati));
    end
    cpu_rd = '0; cpu_wr = '0; cpu_dat_o = DAT;

    // Locked owner (CPU2) is never timed out while CPU1 waits
    cpu_lock = 3'b100;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("lock%0d grant", i), 32'(cpu_grant), 32'h4);
      chk($sformatf("lock%0d timeout_err", i), 32'(timeout_err), 0);
    end

    // Legacy: sel_num=2 grants CPU2 without a request; no timeout applies
    cpu_lock = '0; cpu_req = '0; mode = 1'b0; sel_num = 2'd2;
    step();
    chk("leg release grant", 32'(cpu_grant), 0);
    step();
    chk("leg sel2 grant", 32'(cpu_grant), 32'h4);
    for (int i = 0; i < 8; i++) step();
    chk("leg hold grant", 32'(cpu_grant), 32'h4);
    chk("leg hold timeout_err", 32'(timeout_err), 0);

    // Select change during an access is deferred until the ack
    cpu_wr = 3'b100;
    step();
    chk("leg wr uart_wr", 32'(uart_wr), 1);
    chk("leg wr uart_din", 32'(uart_din), 32'h33);
    cpu_wr = '0; sel_num = 2'd1;
    step();
    chk("leg done ack", 32'(cpu_ack), 32'h4);
    chk("leg done uart_wr", 32'(uart_wr), 0);
    step();
    chk("leg own grant", 32'(cpu_grant), 32'h4);
    step();
    chk("leg rel grant", 32'(cpu_grant), 0);
    step();
    chk("leg sel1 grant", 32'(cpu_grant), 32'h2);

    // Out-of-range select grants nobody
    sel_num = 2'd3;
    for (int i = 0; i < 5; i++) step();
    chk("leg sel3 grant", 32'(cpu_grant), 0);

    // Reset in the middle of an access
    mode = 1'b1; cpu_req = 3'b001;
    step();
    chk("rr cpu0 grant", 32'(cpu_grant), 32'h1);
    cpu_wr = 3'b001;
    step();
    chk("pre-reset uart_wr", 32'(uart_wr), 1);
    cpu_wr = '0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    step();
    chk("reset no ack", 32'(cpu_ack), 0);
    #3 rst_n = 1'b1;
    step();
    chk("post-reset grant", 32'(cpu_grant), 32'h1);
    chk("post-reset ack", 32'(cpu_ack), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
